// File: rtl/uart_msg_sender_if.sv
// Request/TX-FIFO bundle between game logic, uart_msg_sender and the UART TX FIFO.
// Latency: none, wires only.
// Backpressure: tx_full travels toward the sender; there is no other handshake.
interface uart_msg_sender_if #(
   parameter int NUM_MSG = 8
);
   localparam int ID_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

   logic                req;
   logic [ID_W-1:0]     req_id;
   logic                tx_full;
   logic                tx_push;
   logic [7:0]          tx_data;
   logic                busy;
   logic                done;
   logic [ID_W-1:0]     cur_id;
   logic [NUM_MSG-1:0]  pending;

   modport master (
      input  req, req_id, tx_full,
      output tx_push, tx_data, busy, done, cur_id, pending
   );

   modport slave (
      output req, req_id, tx_full,
      input  tx_push, tx_data, busy, done, cur_id, pending
   );
endinterface

// File: rtl/uart_msg_sender.sv
// Streams ROM messages by ID into the UART TX FIFO, lowest pending ID first; UART_MSG_NEWLINE_EN appends 0x0A.
// Latency: req to first push is 2 cycles; 1 byte/cycle afterwards, one DONE and one IDLE cycle between messages.
// Backpressure: tx_full freezes the byte index and state; pushes resume at the stalled byte.
module uart_msg_sender #(
   parameter int NUM_MSG = 8,
   parameter int MAX_LEN = 8,
   parameter logic [NUM_MSG*MAX_LEN*8-1:0]           MSG_ROM = '0,
   parameter logic [NUM_MSG*$clog2(MAX_LEN+1)-1:0]   MSG_LEN = '0
) (
   input logic               clk,
   input logic               reset,
   uart_msg_sender_if.master bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int ID_W  = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_TERM, S_DONE} state_t;

`ifdef UART_MSG_NEWLINE_EN
   localparam state_t S_TAIL = S_TERM;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t             state_q, state_d;
   logic [NUM_MSG-1:0] pending_q, pending_d, set_vec, clr_vec;
   logic [ID_W-1:0]    cur_id_q, cur_id_d, low_id;
   logic [LEN_W-1:0]   idx_q, idx_d, cur_len;
   logic               push_c;
   logic [7:0]         data_c;

   // Oversized table lengths are clamped so idx never walks past the message slot.
   function automatic logic [LEN_W-1:0] len_of(input logic [ID_W-1:0] id);
      logic [LEN_W-1:0] raw;
      raw = MSG_LEN[int'(id)*LEN_W +: LEN_W];
      return (int'(raw) > MAX_LEN) ? LEN_W'(MAX_LEN) : raw;
   endfunction

   assign cur_len = len_of(cur_id_q);

   always_comb begin
      low_id = '0;
      for (int i = NUM_MSG - 1; i >= 0; i--) begin
         if (pending_q[i]) low_id = ID_W'(i);
      end
   end

   always_comb begin
      set_vec = '0;
      if (bus.req && (int'(bus.req_id) < NUM_MSG)) set_vec[bus.req_id] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      cur_id_d = cur_id_q;
      idx_d    = idx_q;
      clr_vec  = '0;
      push_c   = 1'b0;
      data_c   = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               cur_id_d        = low_id;
               clr_vec[low_id] = 1'b1;
               idx_d           = '0;
               state_d         = (len_of(low_id) == '0) ? S_TAIL : S_SEND;
            end
         end
         S_SEND: begin
            if (!bus.tx_full) begin
               push_c = 1'b1;
               data_c = MSG_ROM[(int'(cur_id_q)*MAX_LEN + int'(idx_q))*8 +: 8];
               idx_d  = idx_q + LEN_W'(1);
               if (idx_q == cur_len - LEN_W'(1)) state_d = S_TAIL;
            end
         end
         S_TERM: begin
`ifdef UART_MSG_NEWLINE_EN
            if (!bus.tx_full) begin
               push_c  = 1'b1;
               data_c  = 8'h0A;
               state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Clear is applied before set so a request landing on the captured ID survives.
   assign pending_d = (pending_q & ~clr_vec) | set_vec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         cur_id_q  <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cur_id_q  <= cur_id_d;
         idx_q     <= idx_d;
      end
   end

   assign bus.tx_push = push_c;
   assign bus.tx_data = data_c;
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.cur_id  = cur_id_q;
   assign bus.pending = pending_q;
endmodule
